// File: rtl/irq_sequencer.sv
// Vectored interrupt sequencer: edge-detects source lines, masks and prioritises them,
// and issues a committed redirect request to the core with EPC capture and eret handling.
module irq_sequencer #(
  parameter int unsigned NUM_SRC    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         irq_in,
  input  logic                       cfg_we,
  input  logic [NUM_SRC-1:0]         cfg_data,
  input  logic [31:0]                pc_current,
  input  logic                       irq_ack,
  input  logic                       eret,
  output logic                       irq_req,
  output logic [31:0]                irq_vector,
  output logic [$clog2(NUM_SRC)-1:0] irq_id,
  output logic [31:0]                epc,
  output logic                       busy,
  output logic [NUM_SRC-1:0]         pending
);

  localparam int unsigned IW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state, state_nx;
  logic [NUM_SRC-1:0] sync1, sync2, prev, mask;
  logic [NUM_SRC-1:0] irq_edge, eligible, clr;
  logic [IW-1:0]      sel_id;
  logic               any_elig, take_req, take_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign irq_edge = sync2 & ~prev;
  assign eligible = pending & mask;

  // Lowest eligible index wins.
  always_comb begin
    sel_id   = '0;
    any_elig = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && !any_elig) begin
        sel_id   = IW'(i);
        any_elig = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_elig) state_nx = REQ;
      REQ:     if (irq_ack)  state_nx = SERVICE;
      SERVICE: if (eret)     state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_comb begin
    irq_req = (state == REQ);
    busy    = (state == SERVICE);
  end

  assign take_req = (state == IDLE) && any_elig;
  assign take_ack = (state == REQ) && irq_ack;

  always_comb begin
    clr = '0;
    if (take_ack) clr[irq_id] = 1'b1;
  end

  // A same-cycle edge on the acknowledged source re-sets its bit, so set wins over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      mask       <= '0;
      irq_id     <= '0;
      irq_vector <= '0;
      epc        <= '0;
    end else begin
      pending <= (pending & ~clr) | irq_edge;
      if (cfg_we) mask <= cfg_data;
      if (take_req) begin
        irq_id     <= sel_id;
        irq_vector <= VEC_BASE + (32'(sel_id) * VEC_STRIDE);
      end
      if (take_ack) epc <= pc_current;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_irq_sequencer;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          cfg_we = 1'b0;
  logic [N-1:0]  cfg_data = '0;
  logic [31:0]   pc_current = '0;
  logic          irq_ack = 1'b0;
  logic          eret = 1'b0;
  logic          irq_req;
  logic [31:0]   irq_vector;
  logic [2:0]    irq_id;
  logic [31:0]   epc;
  logic          busy;
  logic [N-1:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  irq_sequencer #(.NUM_SRC(N), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(8)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_data(cfg_data),
    .pc_current(pc_current), .irq_ack(irq_ack), .eret(eret), .irq_req(irq_req),
    .irq_vector(irq_vector), .irq_id(irq_id), .epc(epc), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a source edge is "sampled high two clocks ago, low three clocks ago".
  logic [N-1:0] hist[$];
  logic [N-1:0] m_pend = '0, m_mask = '0;
  logic         m_requesting = 1'b0, m_in_handler = 1'b0;
  int           m_id = 0;
  logic [31:0]  m_vec = '0, m_epc = '0;

  initial begin
    logic [N-1:0] elig, clr;
    hist = '{'0, '0, '0};
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        hist = '{'0, '0, '0};
        m_pend = '0; m_mask = '0; m_requesting = 1'b0; m_in_handler = 1'b0;
        m_id = 0; m_vec = '0; m_epc = '0;
      end else begin
        elig = m_pend & m_mask;
        clr  = '0;
        if (m_requesting) begin
          if (irq_ack) begin
            clr[m_id] = 1'b1;
            m_epc = pc_current;
            m_requesting = 1'b0;
            m_in_handler = 1'b1;
          end
        end else if (m_in_handler) begin
          if (eret) m_in_handler = 1'b0;
        end else if (elig != '0) begin
          for (int i = N - 1; i >= 0; i--) if (elig[i]) m_id = i;
          m_vec = 32'h100 + 32'(m_id) * 32'd8;
          m_requesting = 1'b1;
        end
        m_pend = (m_pend & ~clr) | (hist[1] & ~hist[2]);
        if (cfg_we) m_mask = cfg_data;
        hist.push_front(irq_in);
        hist.delete(3);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("irq_req",    {31'd0, irq_req}, {31'd0, m_requesting});
        chk("busy",       {31'd0, busy},    {31'd0, m_in_handler});
        chk("pending",    32'(pending),     32'(m_pend));
        chk("irq_id",     32'(irq_id),      32'(m_id));
        chk("irq_vector", irq_vector,       m_vec);
        chk("epc",        epc,              m_epc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    cfg_we = 1'b1; cfg_data = m; step(1); cfg_we = 1'b0;
  endtask

  // Acknowledge, then eret; returns at the negedge right after the eret edge.
  task automatic ack_eret(input logic [31:0] pc);
    irq_ack = 1'b1; pc_current = pc; step(1); irq_ack = 1'b0;
    step(1); eret = 1'b1; step(1); eret = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #2;
    chk("rst_irq_req", {31'd0, irq_req}, 32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_pending", 32'(pending),     32'd0);
    chk("rst_epc",     epc,              32'd0);
    chk("rst_vector",  irq_vector,       32'd0);
    chk("rst_id",      32'(irq_id),      32'd0);
    step(2); reset = 1'b0;

    // Single source latency and vector.
    set_mask(8'hFF);
    irq_in = 8'h08; step(1); irq_in = '0;
    step(1); chk("s3_pend_k1", 32'(pending), 32'h00);
    step(1); chk("s3_pend_k2", 32'(pending), 32'h08);
    chk("s3_noreq_k2", {31'd0, irq_req}, 32'd0);
    step(1); chk("s3_req", {31'd0, irq_req}, 32'd1);
    chk("s3_id", 32'(irq_id), 32'd3);
    chk("s3_vec", irq_vector, 32'h118);
    irq_ack = 1'b1; pc_current = 32'h200; step(1); irq_ack = 1'b0;
    chk("s3_busy", {31'd0, busy}, 32'd1);
    chk("s3_epc", epc, 32'h200);
    chk("s3_pend_clr", 32'(pending), 32'h00);
    step(2); eret = 1'b1; step(1); eret = 1'b0;
    chk("s3_idle", {31'd0, busy}, 32'd0);

    // Simultaneous sources 1 and 5.
    irq_in = 8'h22; step(1); irq_in = '0; step(3);
    chk("pri_id", 32'(irq_id), 32'd1);
    chk("pri_vec", irq_vector, 32'h108);
    irq_ack = 1'b1; pc_current = 32'h40; step(1); irq_ack = 1'b0; pc_current = 32'h999;
    for (int i = 0; i < 3; i++) begin
      chk("pri_epc_hold", epc, 32'h40);
      step(1);
    end
    eret = 1'b1; step(1); eret = 1'b0;
    chk("pri_gap", {31'd0, irq_req}, 32'd0);
    step(1);
    chk("pri2_id", 32'(irq_id), 32'd5);
    chk("pri2_vec", irq_vector, 32'h128);
    chk("pri2_epc", epc, 32'h40);
    ack_eret(32'h300);

    // Masked source stays pending, then unmask.
    set_mask(8'h00);
    irq_in = 8'h04; step(1); irq_in = '0; step(4);
    chk("msk_pend", 32'(pending), 32'h04);
    chk("msk_noreq", {31'd0, irq_req}, 32'd0);
    set_mask(8'h04);
    chk("msk_wait", {31'd0, irq_req}, 32'd0);
    step(1);
    chk("msk_req", {31'd0, irq_req}, 32'd1);
    chk("msk_vec", irq_vector, 32'h110);
    ack_eret(32'h310);
    set_mask(8'hFF);

    // Committed request is not preempted.
    irq_in = 8'h10; step(1); irq_in = '0; step(3);
    chk("cmt_id0", 32'(irq_id), 32'd4);
    irq_in = 8'h01; step(1); irq_in = '0; step(3);
    chk("cmt_id", 32'(irq_id), 32'd4);
    chk("cmt_pend", 32'(pending), 32'h11);
    ack_eret(32'h320);
    step(1);
    chk("cmt_next_id", 32'(irq_id), 32'd0);
    chk("cmt_next_vec", irq_vector, 32'h100);
    ack_eret(32'h330);

    // Second edge lands on the ack edge of the same source.
    irq_in = 8'h40; step(1); irq_in = '0; step(1); irq_in = 8'h40; step(1); irq_in = '0; step(1);
    chk("sw_req_id", 32'(irq_id), 32'd6);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    chk("sw_pend", 32'(pending), 32'h40);
    eret = 1'b1; step(1); eret = 1'b0; step(1);
    chk("sw_rereq", {31'd0, irq_req}, 32'd1);
    chk("sw_rereq_id", 32'(irq_id), 32'd6);
    ack_eret(32'h340);

    // Reset during service; level held across release becomes an edge.
    irq_in = 8'h02; step(1); irq_in = '0; step(3);
    irq_ack = 1'b1; pc_current = 32'h500; step(1); irq_ack = 1'b0;
    irq_in = 8'h08; step(1); irq_in = '0; step(3);
    chk("rs_pend_pre", 32'(pending), 32'h08);
    chk("rs_epc_pre", epc, 32'h500);
    irq_in = 8'h80;
    #2 reset = 1'b1;
    #1;
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_epc", epc, 32'd0);
    chk("rs_pend", 32'(pending), 32'd0);
    chk("rs_req", {31'd0, irq_req}, 32'd0);
    step(2); reset = 1'b0;
    step(3);
    chk("rs_level_edge", 32'(pending), 32'h80);
    step(1);
    chk("rs_masked", {31'd0, irq_req}, 32'd0);
    set_mask(8'hFF);
    step(1);
    chk("rs_req7", 32'(irq_id), 32'd7);
    chk("rs_vec7", irq_vector, 32'h138);
    irq_in = '0;
    ack_eret(32'h350);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      irq_ack    = ($urandom_range(0, 2) == 0);
      eret       = ($urandom_range(0, 4) == 0);
      pc_current = $urandom;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 9) == 0) irq_in[b] = ~irq_in[b];
      cfg_we   = ($urandom_range(0, 15) == 0);
      cfg_data = N'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        step(1);
        reset = 1'b0;
      end else begin
        step(1);
      end
    end
    irq_ack = 1'b0; eret = 1'b0; cfg_we = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
